reaction_timer: RTL and testbench

Game-control stage that consumes the 5-bit pseudo-random word from the team's LFSR RNG and runs a reaction-time round. On `start` it latches `rnd`, waits a random delay, then lights `led`. It measures milliseconds until `react` and reports the result to the display/scoring logic. Sits directly downstream of the RNG, upstream of the 7-segment/score block.

---
 rtl/reaction_timer.sv | 133 +++++++++++++
 tb/tb_reaction_timer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer.sv
// Reaction-time round controller: random delay, go-lamp, ms measurement of the response.
// Latency: led rises target*TICK_DIV cycles after accepted start; result_valid one edge after react.
// Backpressure: none; start/react are single-cycle pulses, ignored in states that do not use them.
module reaction_timer #(
    parameter int TICK_DIV      = 100000,
    parameter int DELAY_BASE_MS = 1000,
    parameter int DELAY_STEP_MS = 100,
    parameter int MAX_MS        = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        react,
    input  logic [4:0]  rnd,
    output logic        led,
    output logic        busy,
    output logic [13:0] result_ms,
    output logic        result_valid,
    output logic        early,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ARMED,
        S_DONE,
        S_FALSE
    } state_t;

    localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TGT_MAX = DELAY_BASE_MS + 31 * DELAY_STEP_MS;
    localparam int CNT_MAX = (TGT_MAX > MAX_MS) ? TGT_MAX : MAX_MS;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [PW-1:0] PS_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PS_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] MAX_LAST = CW'(MAX_MS - 1);
    localparam logic [13:0]   MAX_RES  = 14'(MAX_MS);

    state_t        state;
    logic [PW-1:0] prescaler;
    logic [CW-1:0] ms_cnt;
    logic [CW-1:0] target;
    logic          tick;
    logic          accept;
    logic [CW-1:0] rnd_target;

    assign tick       = (prescaler == PS_LAST);
    assign accept     = start && (state inside {S_IDLE, S_DONE, S_FALSE});
    // Counter width covers the largest delay (rnd=31), so this never truncates.
    assign rnd_target = CW'(DELAY_BASE_MS) + CW'(rnd) * CW'(DELAY_STEP_MS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            prescaler    <= '0;
            ms_cnt       <= '0;
            target       <= '0;
            led          <= 1'b0;
            busy         <= 1'b0;
            result_ms    <= '0;
            result_valid <= 1'b0;
            early        <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (accept) begin
                state     <= S_WAIT;
                prescaler <= '0;
                ms_cnt    <= '0;
                target    <= rnd_target;
                busy      <= 1'b1;
                led       <= 1'b0;
                early     <= 1'b0;
                timeout   <= 1'b0;
                result_ms <= '0;
            end else begin
                case (state)
                    S_WAIT: begin
                        // A press on the final tick is still a false start.
                        if (react) begin
                            state     <= S_FALSE;
                            prescaler <= '0;
                            busy      <= 1'b0;
                            early     <= 1'b1;
                        end else if (tick) begin
                            prescaler <= '0;
                            if (ms_cnt == target - CNT_ONE) begin
                                state  <= S_ARMED;
                                ms_cnt <= '0;
                                led    <= 1'b1;
                            end else begin
                                ms_cnt <= ms_cnt + CNT_ONE;
                            end
                        end else begin
                            prescaler <= prescaler + PS_ONE;
                        end
                    end
                    S_ARMED: begin
                        if (react) begin
                            state        <= S_DONE;
                            prescaler    <= '0;
                            led          <= 1'b0;
                            busy         <= 1'b0;
                            result_ms    <= 14'(ms_cnt);
                            result_valid <= 1'b1;
                            timeout      <= 1'b0;
                        end else if (tick) begin
                            prescaler <= '0;
                            if (ms_cnt == MAX_LAST) begin
                                state        <= S_DONE;
                                led          <= 1'b0;
                                busy         <= 1'b0;
                                result_ms    <= MAX_RES;
                                result_valid <= 1'b1;
                                timeout      <= 1'b1;
                            end else begin
                                ms_cnt <= ms_cnt + CNT_ONE;
                            end
                        end else begin
                            prescaler <= prescaler + PS_ONE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer: directed rounds then random start/react traffic vs an event-time model.
module tb_reaction_timer;

    localparam int TD    = 4;
    localparam int BASE  = 2;
    localparam int STEP  = 1;
    localparam int MAXMS = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        react = 1'b0;
    logic [4:0]  rnd = '0;
    logic        led, busy, result_valid, early, timeout;
    logic [13:0] result_ms;

    reaction_timer #(
        .TICK_DIV(TD),
        .DELAY_BASE_MS(BASE),
        .DELAY_STEP_MS(STEP),
        .MAX_MS(MAXMS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .react(react),
        .rnd(rnd),
        .led(led),
        .busy(busy),
        .result_ms(result_ms),
        .result_valid(result_valid),
        .early(early),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Round model in absolute edge times: accept edge, lamp edge, end edge.
    int n = 0;
    bit have_round = 0;
    bit ended = 0;
    int t0 = 0, tgt = 0, kind = 0, e_end = 0, res = 0;
    bit to_flag = 0;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        have_round = 0;
        ended      = 0;
    endfunction

    function automatic void model_edge(input bit s, input bit r, input int rn);
        int rise, tout;
        n++;
        if (!reset) begin
            model_clear();
        end else if ((!have_round || ended) && s) begin
            have_round = 1;
            ended      = 0;
            t0         = n;
            tgt        = BASE + rn * STEP;
        end else if (have_round && !ended) begin
            rise = t0 + tgt * TD;
            tout = rise + MAXMS * TD;
            if (r) begin
                ended = 1;
                e_end = n;
                if (n <= rise) begin
                    kind = 1;
                end else begin
                    kind    = 2;
                    res     = (n - rise - 1) / TD;
                    to_flag = 0;
                end
            end else if (n == tout) begin
                ended   = 1;
                e_end   = n;
                kind    = 2;
                res     = MAXMS;
                to_flag = 1;
            end
        end
    endfunction

    task automatic check_outputs();
        int x_led, x_busy, x_early, x_res, x_to, x_rv;
        x_led   = (have_round && !ended && n >= t0 + tgt * TD) ? 1 : 0;
        x_busy  = (have_round && !ended) ? 1 : 0;
        x_early = (have_round && ended && kind == 1) ? 1 : 0;
        x_res   = (have_round && ended && kind == 2) ? res : 0;
        x_to    = (have_round && ended && kind == 2 && to_flag) ? 1 : 0;
        x_rv    = (have_round && ended && kind == 2 && n == e_end) ? 1 : 0;
        check("led", {31'd0, led}, x_led);
        check("busy", {31'd0, busy}, x_busy);
        check("early", {31'd0, early}, x_early);
        check("result_ms", {18'd0, result_ms}, x_res);
        check("timeout", {31'd0, timeout}, x_to);
        check("result_valid", {31'd0, result_valid}, x_rv);
    endtask

    task automatic step(input bit s, input bit r, input logic [4:0] rn);
        start = s;
        react = r;
        rnd   = rn;
        @(posedge clk);
        model_edge(s, r, int'(rn));
        @(negedge clk);
        start = 1'b0;
        react = 1'b0;
        check_outputs();
    endtask

    initial begin
        // Power-on reset
        repeat (3) @(negedge clk);
        model_clear();
        check_outputs();
        check("reset_result", {18'd0, result_ms}, 0);
        reset = 1'b1;

        // Asynchronous reset while ARMED
        step(1, 0, 5'd1);
        repeat (14) step(0, 0, 5'd0);
        check("rst_pre_led", {31'd0, led}, 1);
        reset = 1'b0;
        model_clear();
        #1;
        check("rst_async_led", {31'd0, led}, 0);
        check("rst_async_busy", {31'd0, busy}, 0);
        check_outputs();
        repeat (3) step(0, 0, 5'd0);
        reset = 1'b1;

        // rnd=5: lamp after 28 cycles, response after three full ticks
        step(1, 0, 5'd5);
        check("s2_busy", {31'd0, busy}, 1);
        repeat (27) step(0, 0, 5'd0);
        check("s2_led_before", {31'd0, led}, 0);
        step(0, 0, 5'd0);
        check("s2_led_rise", {31'd0, led}, 1);
        repeat (12) step(0, 0, 5'd0);
        step(0, 1, 5'd0);
        check("s2_result", {18'd0, result_ms}, 3);
        check("s2_valid", {31'd0, result_valid}, 1);
        check("s2_timeout", {31'd0, timeout}, 0);
        step(0, 0, 5'd0);
        check("s2_valid_pulse", {31'd0, result_valid}, 0);
        check("s2_result_held", {18'd0, result_ms}, 3);

        // rnd=0: false start in WAIT, then restart clears early
        step(1, 0, 5'd0);
        repeat (4) step(0, 0, 5'd0);
        step(0, 1, 5'd0);
        check("s3_early", {31'd0, early}, 1);
        check("s3_valid", {31'd0, result_valid}, 0);
        repeat (10) step(0, 0, 5'd0);
        check("s3_led_off", {31'd0, led}, 0);
        step(1, 0, 5'd3);
        check("s3_early_clear", {31'd0, early}, 0);
        check("s3_busy", {31'd0, busy}, 1);
        step(0, 1, 5'd0);

        // rnd=31: no response, timeout saturates at MAX_MS
        step(1, 0, 5'd31);
        repeat (131) step(0, 0, 5'd0);
        check("s4_led_before", {31'd0, led}, 0);
        step(0, 0, 5'd0);
        check("s4_led_rise", {31'd0, led}, 1);
        repeat (79) step(0, 0, 5'd0);
        check("s4_still_armed", {31'd0, busy}, 1);
        step(0, 0, 5'd0);
        check("s4_result", {18'd0, result_ms}, MAXMS);
        check("s4_timeout", {31'd0, timeout}, 1);
        check("s4_valid", {31'd0, result_valid}, 1);

        // React on the final WAIT tick is a false start
        step(1, 0, 5'd0);
        repeat (7) step(0, 0, 5'd0);
        step(0, 1, 5'd0);
        check("s5_early", {31'd0, early}, 1);
        check("s5_led", {31'd0, led}, 0);

        // start+react together in DONE: new round, react ignored
        step(1, 0, 5'd0);
        repeat (8) step(0, 0, 5'd0);
        check("s6_armed", {31'd0, led}, 1);
        repeat (9) step(0, 0, 5'd0);
        step(0, 1, 5'd0);
        check("s6_result", {18'd0, result_ms}, 2);
        step(1, 1, 5'd7);
        check("s6_busy", {31'd0, busy}, 1);
        check("s6_result_clr", {18'd0, result_ms}, 0);
        check("s6_early", {31'd0, early}, 0);
        repeat (35) step(0, 0, 5'd0);
        check("s6_led_before", {31'd0, led}, 0);
        step(0, 0, 5'd0);
        check("s6_led_rise", {31'd0, led}, 1);

        // Random traffic with varying response rates
        for (int blk = 0; blk < 15; blk++) begin
            int rp;
            rp = (blk % 3 == 0) ? 8 : ((blk % 3 == 1) ? 40 : 400);
            for (int c = 0; c < 200; c++) begin
                step($urandom_range(0, 29) == 0, $urandom_range(0, rp - 1) == 0,
                     5'($urandom_range(0, 31)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
